// File: rtl/rv_pkg.sv
// rv_pkg: shared load funct3 codes and writeback state encoding.
package rv_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   typedef enum logic {WB_IDLE = 1'b0, WB_WAIT_RSP = 1'b1} wb_state_e;
endpackage

// File: rtl/rv_writeback_if.sv
// rv_writeback_if: MEM-stage, data-bus response and register-file/hazard signals of the writeback stage.
interface rv_writeback_if #(parameter int RET_W = 32);
   logic              in_valid;
   logic              in_ready;
   logic              in_rd_we;
   logic [4:0]        in_rd_addr;
   logic              in_is_load;
   logic [2:0]        in_funct3;
   logic [1:0]        in_addr_lo;
   logic [31:0]       in_result;
   logic              dmem_rvalid;
   logic [31:0]       dmem_rdata;
   logic              dmem_err;
   logic              rd_we;
   logic [4:0]        rd_addr;
   logic [31:0]       rd_data;
   logic              fwd_valid;
   logic [4:0]        fwd_addr;
   logic [31:0]       fwd_data;
   logic              pend_valid;
   logic [4:0]        pend_rd;
   logic              load_err;
   logic              retire;
   logic [RET_W-1:0]  instret_count;
   modport master (
      output in_valid, in_rd_we, in_rd_addr, in_is_load, in_funct3, in_addr_lo, in_result,
             dmem_rvalid, dmem_rdata, dmem_err,
      input  in_ready, rd_we, rd_addr, rd_data, fwd_valid, fwd_addr, fwd_data,
             pend_valid, pend_rd, load_err, retire, instret_count
   );
   modport slave (
      input  in_valid, in_rd_we, in_rd_addr, in_is_load, in_funct3, in_addr_lo, in_result,
             dmem_rvalid, dmem_rdata, dmem_err,
      output in_ready, rd_we, rd_addr, rd_data, fwd_valid, fwd_addr, fwd_data,
             pend_valid, pend_rd, load_err, retire, instret_count
   );
endinterface

// File: rtl/rv_load_ext.sv
// rv_load_ext: selects and sign/zero-extends the load lane, flagging illegal width/alignment.
module rv_load_ext import rv_pkg::*; (
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data,
   output logic        o_illegal
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   assign o_data = (i_funct3 == F3_LB)  ? {{24{w_byte[7]}}, w_byte} :
                   (i_funct3 == F3_LH)  ? {{16{w_half[15]}}, w_half} :
                   (i_funct3 == F3_LW)  ? i_rdata :
                   (i_funct3 == F3_LBU) ? {24'd0, w_byte} :
                   (i_funct3 == F3_LHU) ? {16'd0, w_half} : 32'd0;
   // funct3[1:0]==01 covers both LH and LHU
   assign o_illegal = !(i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) ||
                      (i_funct3[1:0] == 2'b01 && i_addr_lo[0]) ||
                      (i_funct3 == F3_LW && i_addr_lo != 2'd0);
endmodule

// File: rtl/rv_writeback.sv
// rv_writeback: RV32I writeback stage; retires ALU results directly and waits on the data bus for loads.
module rv_writeback import rv_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMO_W          = 8,
   parameter int RET_W          = 32
) (
   input logic           clk,
   input logic           rst,
   rv_writeback_if.slave wb
);
   wb_state_e        r_state, w_next;
   logic [TMO_W-1:0] r_timer, w_timer;
   logic             r_ld_we;
   logic [4:0]       r_ld_rd;
   logic [2:0]       r_ld_f3;
   logic [1:0]       r_ld_lo;
   logic             r_rd_we, r_load_err, r_retire;
   logic [4:0]       r_rd_addr;
   logic [31:0]      r_rd_data;
   logic [RET_W-1:0] r_instret;
   logic             w_we, w_err, w_ret, w_latch, w_illegal;
   logic [4:0]       w_addr;
   logic [31:0]      w_data, w_ext;
   rv_load_ext u_ext (
      .i_funct3  (r_ld_f3),
      .i_addr_lo (r_ld_lo),
      .i_rdata   (wb.dmem_rdata),
      .o_data    (w_ext),
      .o_illegal (w_illegal)
   );
   always_ff @(posedge clk) begin
      if (rst) r_state <= WB_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next  = r_state;
      w_timer = r_timer;
      w_we    = 1'b0;
      w_err   = 1'b0;
      w_ret   = 1'b0;
      w_latch = 1'b0;
      w_addr  = wb.in_rd_addr;
      w_data  = wb.in_result;
      if (r_state == WB_IDLE) begin
         if (wb.in_valid && !wb.in_is_load) begin
            w_ret = 1'b1;
            w_we  = wb.in_rd_we && wb.in_rd_addr != 5'd0;
         end else if (wb.in_valid) begin
            w_latch = 1'b1;
            w_timer = '0;
            w_next  = WB_WAIT_RSP;
         end
      end else if (wb.dmem_rvalid) begin
         // a response in the timeout cycle still completes the load
         w_next = WB_IDLE;
         w_err  = wb.dmem_err || w_illegal;
         w_ret  = !w_err;
         w_we   = !w_err && r_ld_we && r_ld_rd != 5'd0;
         w_addr = r_ld_rd;
         w_data = w_ext;
      end else if (r_timer == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         w_next = WB_IDLE;
         w_err  = 1'b1;
      end else begin
         w_timer = r_timer + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer    <= '0;
         r_ld_we    <= 1'b0;
         r_ld_rd    <= '0;
         r_ld_f3    <= '0;
         r_ld_lo    <= '0;
         r_rd_we    <= 1'b0;
         r_rd_addr  <= '0;
         r_rd_data  <= '0;
         r_load_err <= 1'b0;
         r_retire   <= 1'b0;
         r_instret  <= '0;
      end else begin
         r_timer    <= w_timer;
         r_rd_we    <= w_we;
         r_load_err <= w_err;
         r_retire   <= w_ret;
         r_instret  <= r_instret + RET_W'(w_ret);
         if (w_we) begin
            r_rd_addr <= w_addr;
            r_rd_data <= w_data;
         end
         if (w_latch) begin
            r_ld_we <= wb.in_rd_we;
            r_ld_rd <= wb.in_rd_addr;
            r_ld_f3 <= wb.in_funct3;
            r_ld_lo <= wb.in_addr_lo;
         end
      end
   end
   assign wb.in_ready      = r_state == WB_IDLE;
   assign wb.rd_we         = r_rd_we;
   assign wb.rd_addr       = r_rd_addr;
   assign wb.rd_data       = r_rd_data;
   assign wb.fwd_valid     = r_rd_we;
   assign wb.fwd_addr      = r_rd_addr;
   assign wb.fwd_data      = r_rd_data;
   assign wb.pend_valid    = r_state == WB_WAIT_RSP && r_ld_we && r_ld_rd != 5'd0;
   assign wb.pend_rd       = wb.pend_valid ? r_ld_rd : 5'd0;
   assign wb.load_err      = r_load_err;
   assign wb.retire        = r_retire;
   assign wb.instret_count = r_instret;
endmodule
